// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage sequencer: opcodes, status bits,
// instruction classes, branch conditions and FSM state encoding.
package alu_pkg;

  localparam int unsigned InstrWidth = 16;

  typedef enum logic [2:0] {
    AluAdd = 3'd0,
    AluSub = 3'd1,
    AluMul = 3'd2,
    AluDiv = 3'd3,
    AluAnd = 3'd4,
    AluOr  = 3'd5,
    AluXor = 3'd6,
    AluCmp = 3'd7
  } alu_op_e;

  // Bit positions inside the ALU status word (z|e|gt|lt|cf|0|0|0).
  localparam int unsigned SW_Z  = 7;
  localparam int unsigned SW_E  = 6;
  localparam int unsigned SW_GT = 5;
  localparam int unsigned SW_LT = 4;
  localparam int unsigned SW_CF = 3;

  typedef enum logic [1:0] {
    ClsNop    = 2'b00,
    ClsAluReg = 2'b01,
    ClsAluImm = 2'b10,
    ClsBranch = 2'b11
  } instr_class_e;

  typedef enum logic [2:0] {
    CondAlways = 3'd0,
    CondZ      = 3'd1,
    CondE      = 3'd2,
    CondGt     = 3'd3,
    CondLt     = 3'd4,
    CondGe     = 3'd5,
    CondNe     = 3'd6,
    CondLe     = 3'd7
  } branch_cond_e;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StExec   = 2'd1,
    StBranch = 2'd2
  } state_e;

  // Immediate DIV with a zero divisor is suppressed rather than issued.
  function automatic logic is_div_zero(logic [InstrWidth-1:0] w);
    return (w[15:14] == ClsAluImm) && (w[13:11] == AluDiv) && (w[7:0] == 8'h00);
  endfunction

endpackage

// File: rtl/cond_eval.sv
// Combinational branch-condition evaluator over the ALU status word.
// The carry flag never participates in any condition.
module cond_eval
  import alu_pkg::*;
(
  input  logic [7:0] status_word_i,
  input  logic [2:0] cond_i,
  output logic       taken_o
);

  logic z, e, gt, lt;
  logic unused_sw;

  assign z  = status_word_i[SW_Z];
  assign e  = status_word_i[SW_E];
  assign gt = status_word_i[SW_GT];
  assign lt = status_word_i[SW_LT];
  assign unused_sw = ^status_word_i[3:0];

  always_comb begin
    taken_o = 1'b0;
    unique case (branch_cond_e'(cond_i))
      CondAlways: taken_o = 1'b1;
      CondZ:      taken_o = z;
      CondE:      taken_o = e;
      CondGt:     taken_o = gt;
      CondLt:     taken_o = lt;
      CondGe:     taken_o = gt | e;
      CondNe:     taken_o = ~e;
      CondLe:     taken_o = lt | e;
    endcase
  end

endmodule

// File: rtl/alu_ctrl.sv
// Execute-stage sequencer: accepts one instruction per handshake, issues it to
// the ALU for one cycle or evaluates a branch for one cycle, then returns to idle.
module alu_ctrl
  import alu_pkg::*;
#(
  parameter int unsigned IW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          instr_valid,
  input  logic [IW-1:0] instr,
  output logic          instr_ready,
  input  logic [7:0]    status_word,
  output logic [2:0]    rd_sel,
  output logic [2:0]    rb_sel,
  output logic [2:0]    alu_opr,
  output logic          alu_en,
  output logic [7:0]    direct_data_bus,
  output logic          direct_data_bus_en,
  output logic          reg_wr_en,
  output logic          branch_taken,
  output logic [7:0]    branch_target,
  output logic          div_zero_err
);

  state_e        state_q;
  logic [IW-1:0] instr_q;
  logic          ready_q;
  logic          alu_en_q;
  logic          imm_en_q;
  logic [7:0]    imm_q;
  logic          wr_en_q;
  logic          div_zero_q;

  instr_class_e  in_class;
  alu_op_e       in_opr;
  logic          in_div_zero;
  logic          accept;
  logic          cond_true;

  always_comb begin
    in_class    = instr_class_e'(instr[15:14]);
    in_opr      = alu_op_e'(instr[13:11]);
    in_div_zero = is_div_zero(instr);
    accept      = instr_valid && ready_q && (state_q == StIdle);
  end

  // Outputs for the EXEC slot are computed at the accept edge so they come
  // straight from flops during EXEC.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      instr_q    <= '0;
      ready_q    <= 1'b0;
      alu_en_q   <= 1'b0;
      imm_en_q   <= 1'b0;
      imm_q      <= '0;
      wr_en_q    <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= StIdle;
      ready_q    <= 1'b1;
      alu_en_q   <= 1'b0;
      imm_en_q   <= 1'b0;
      imm_q      <= '0;
      wr_en_q    <= 1'b0;
      div_zero_q <= 1'b0;
      if (accept) begin
        instr_q <= instr;
        unique case (in_class)
          ClsNop: ;
          ClsAluReg, ClsAluImm: begin
            state_q    <= StExec;
            ready_q    <= 1'b0;
            alu_en_q   <= ~in_div_zero;
            wr_en_q    <= (in_opr != AluCmp) && !in_div_zero;
            imm_en_q   <= (in_class == ClsAluImm) && !in_div_zero;
            imm_q      <= (in_class == ClsAluImm) ? instr[7:0] : 8'h00;
            div_zero_q <= in_div_zero;
          end
          ClsBranch: begin
            state_q <= StBranch;
            ready_q <= 1'b0;
          end
        endcase
      end
    end
  end

  cond_eval u_cond_eval (
    .status_word_i(status_word),
    .cond_i       (instr_q[13:11]),
    .taken_o      (cond_true)
  );

  assign instr_ready        = ready_q;
  assign alu_opr            = instr_q[13:11];
  assign rd_sel             = instr_q[10:8];
  assign rb_sel             = instr_q[7:5];
  assign alu_en             = alu_en_q;
  assign direct_data_bus_en = imm_en_q;
  assign direct_data_bus    = imm_q;
  assign reg_wr_en          = wr_en_q;
  assign div_zero_err       = div_zero_q;

  // The branch decision must see status_word during the BRANCH cycle itself,
  // so it is resolved combinationally from the latched condition.
  assign branch_taken  = (state_q == StBranch) && cond_true;
  assign branch_target = branch_taken ? instr_q[7:0] : 8'h00;

endmodule

// File: tb/tb_alu_ctrl.sv
// Self-checking bench for alu_ctrl: expected per-cycle outputs are queued when
// stimulus is driven and compared as each cycle's outputs appear.
module tb_alu_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic [15:0] instr;
  logic [7:0]  status_word;
  logic        instr_ready;
  logic [2:0]  rd_sel, rb_sel, alu_opr;
  logic        alu_en, direct_data_bus_en, reg_wr_en, branch_taken, div_zero_err;
  logic [7:0]  direct_data_bus, branch_target;

  typedef struct packed {
    logic       ready;
    logic       en;
    logic [2:0] opr;
    logic [2:0] rd;
    logic [2:0] rb;
    logic       imm_en;
    logic [7:0] dbus;
    logic       wr;
    logic       br;
    logic [7:0] tgt;
    logic       dz;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  alu_ctrl #(.IW(16)) dut (
    .clk               (clk),
    .rst               (rst),
    .instr_valid       (instr_valid),
    .instr             (instr),
    .instr_ready       (instr_ready),
    .status_word       (status_word),
    .rd_sel            (rd_sel),
    .rb_sel            (rb_sel),
    .alu_opr           (alu_opr),
    .alu_en            (alu_en),
    .direct_data_bus   (direct_data_bus),
    .direct_data_bus_en(direct_data_bus_en),
    .reg_wr_en         (reg_wr_en),
    .branch_taken      (branch_taken),
    .branch_target     (branch_target),
    .div_zero_err      (div_zero_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t sample();
    return {instr_ready, alu_en, alu_opr, rd_sel, rb_sel, direct_data_bus_en,
            direct_data_bus, reg_wr_en, branch_taken, branch_target, div_zero_err};
  endfunction

  function automatic exp_t mk(logic rdy, logic en, logic [2:0] opr, logic [2:0] rd,
                              logic [2:0] rb, logic imm_en, logic [7:0] dbus, logic wr,
                              logic br, logic [7:0] tgt, logic dz);
    return {rdy, en, opr, rd, rb, imm_en, dbus, wr, br, tgt, dz};
  endfunction

  // Idle cycle after a latched word: strobes low, selects hold the word's fields.
  function automatic exp_t idle_of(logic [15:0] w);
    return mk(1'b1, 1'b0, w[13:11], w[10:8], w[7:5], 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
  endfunction

  function automatic logic model_taken(logic [2:0] cond, logic [7:0] sw);
    logic z, e, gt, lt;
    z = sw[7]; e = sw[6]; gt = sw[5]; lt = sw[4];
    case (cond)
      3'd0:    return 1'b1;
      3'd1:    return z;
      3'd2:    return e;
      3'd3:    return gt;
      3'd4:    return lt;
      3'd5:    return gt | e;
      3'd6:    return !e;
      default: return lt | e;
    endcase
  endfunction

  task automatic test_reset();
    exp_t e, g;
    rst = 1'b1; instr_valid = 1'b0; instr = 16'h0000; status_word = 8'h00;
    sb.push_back('0);
    sb.push_back('0);
    repeat (2) begin
      tick();
      e = sb.pop_front(); g = sample(); checks++;
      if (g !== e) begin errors++; $display("FAIL reset_state: got %h expected %h", g, e); end
    end
    rst = 1'b0;
    sb.push_back(mk(1'b1, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0));
    tick();
    e = sb.pop_front(); g = sample(); checks++;
    if (g !== e) begin errors++; $display("FAIL reset_release: got %h expected %h", g, e); end
  endtask

  task automatic test_alu_reg();
    exp_t e, g;
    instr_valid = 1'b1; instr = 16'h4220;
    sb.push_back(mk(1'b0, 1'b1, 3'd0, 3'd2, 3'd1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0));
    sb.push_back(idle_of(16'h4220));
    tick();
    instr_valid = 1'b0;
    repeat (2) begin
      e = sb.pop_front(); g = sample(); checks++;
      if (g !== e) begin errors++; $display("FAIL alu_reg_add: got %h expected %h", g, e); end
      if (sb.size() != 0) tick();
    end
  endtask

  task automatic test_alu_imm();
    exp_t e, g;
    instr_valid = 1'b1; instr = 16'h8B05;
    sb.push_back(mk(1'b0, 1'b1, 3'd1, 3'd3, 3'd0, 1'b1, 8'h05, 1'b1, 1'b0, 8'h00, 1'b0));
    sb.push_back(idle_of(16'h8B05));
    tick();
    instr_valid = 1'b0;
    repeat (2) begin
      e = sb.pop_front(); g = sample(); checks++;
      if (g !== e) begin errors++; $display("FAIL alu_imm_sub: got %h expected %h", g, e); end
      if (sb.size() != 0) tick();
    end
  endtask

  task automatic test_cmp_branch();
    exp_t e, g;
    instr_valid = 1'b1; instr = 16'h7820;
    sb.push_back(mk(1'b0, 1'b1, 3'd7, 3'd0, 3'd1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0));
    sb.push_back(idle_of(16'h7820));
    tick();
    instr_valid = 1'b0;
    status_word = 8'h40;
    repeat (2) begin
      e = sb.pop_front(); g = sample(); checks++;
      if (g !== e) begin errors++; $display("FAIL cmp_exec: got %h expected %h", g, e); end
      if (sb.size() != 0) tick();
    end
    instr_valid = 1'b1; instr = 16'hD03C;
    sb.push_back(mk(1'b0, 1'b0, 3'd2, 3'd0, 3'd1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h3C, 1'b0));
    sb.push_back(idle_of(16'hD03C));
    instr_valid = 1'b1; instr = 16'hD03C;
    tick();
    instr_valid = 1'b0;
    repeat (2) begin
      e = sb.pop_front(); g = sample(); checks++;
      if (g !== e) begin errors++; $display("FAIL branch_eq_taken: got %h expected %h", g, e); end
      if (sb.size() != 0) tick();
    end
    instr_valid = 1'b1; instr = 16'hF03C;
    sb.push_back(mk(1'b0, 1'b0, 3'd6, 3'd0, 3'd1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0));
    sb.push_back(idle_of(16'hF03C));
    tick();
    instr_valid = 1'b0;
    repeat (2) begin
      e = sb.pop_front(); g = sample(); checks++;
      if (g !== e) begin errors++; $display("FAIL branch_ne_not_taken: got %h expected %h", g, e); end
      if (sb.size() != 0) tick();
    end
  endtask

  task automatic test_branch_sweep();
    exp_t e, g;
    logic [7:0]  sws [4] = '{8'h20, 8'h10, 8'h80, 8'h08};
    logic [15:0] w;
    logic        tk;
    for (int s = 0; s < 4; s++) begin
      for (int c = 0; c < 8; c++) begin
        status_word = sws[s];
        w = {2'b11, 3'(c), 3'(s), 8'(c * 16 + 5)};
        tk = model_taken(3'(c), sws[s]);
        sb.push_back(mk(1'b0, 1'b0, w[13:11], w[10:8], w[7:5], 1'b0, 8'h00, 1'b0,
                        tk, tk ? w[7:0] : 8'h00, 1'b0));
        sb.push_back(idle_of(w));
        instr_valid = 1'b1; instr = w;
        tick();
        instr_valid = 1'b0;
        repeat (2) begin
          e = sb.pop_front(); g = sample(); checks++;
          if (g !== e) begin
            errors++;
            $display("FAIL branch_cond%0d_sw%h: got %h expected %h", c, sws[s], g, e);
          end
          if (sb.size() != 0) tick();
        end
      end
    end
  endtask

  task automatic test_div_zero();
    exp_t e, g;
    instr_valid = 1'b1; instr = 16'h9900;
    sb.push_back(mk(1'b0, 1'b0, 3'd3, 3'd1, 3'd0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1));
    sb.push_back(idle_of(16'h9900));
    tick();
    instr_valid = 1'b0;
    e = sb.pop_front(); g = sample();
    checks++;
    if (g.dz !== e.dz) begin errors++; $display("FAIL div_zero_err: got %b expected %b", g.dz, e.dz); end
    checks++;
    if (g.en !== e.en) begin errors++; $display("FAIL div_zero_alu_en: got %b expected %b", g.en, e.en); end
    checks++;
    if (g.wr !== e.wr) begin errors++; $display("FAIL div_zero_wr_en: got %b expected %b", g.wr, e.wr); end
    checks++;
    if (g.ready !== e.ready) begin errors++; $display("FAIL div_zero_ready: got %b expected %b", g.ready, e.ready); end
    tick();
    e = sb.pop_front(); g = sample(); checks++;
    if (g !== e) begin errors++; $display("FAIL div_zero_after: got %h expected %h", g, e); end
  endtask

  task automatic test_reset_mid_exec();
    exp_t e, g;
    instr_valid = 1'b1; instr = 16'h4220;
    sb.push_back(mk(1'b0, 1'b1, 3'd0, 3'd2, 3'd1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0));
    sb.push_back('0);
    sb.push_back(mk(1'b1, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0));
    sb.push_back(mk(1'b1, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0));
    tick();
    instr_valid = 1'b0;
    e = sb.pop_front(); g = sample(); checks++;
    if (g !== e) begin errors++; $display("FAIL rst_mid_exec_slot: got %h expected %h", g, e); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (3) begin
      e = sb.pop_front(); g = sample(); checks++;
      if (g !== e) begin errors++; $display("FAIL rst_mid_exec_after: got %h expected %h", g, e); end
      if (sb.size() != 0) tick();
    end
  endtask

  task automatic test_back_to_back();
    exp_t e, g;
    logic [15:0] nops [4] = '{16'h0000, 16'h0123, 16'h0ABC, 16'h3FFF};
    instr_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      instr = nops[i];
      sb.push_back(idle_of(nops[i]));
      tick();
      e = sb.pop_front(); g = sample(); checks++;
      if (g !== e) begin errors++; $display("FAIL nop_b2b_%0d: got %h expected %h", i, g, e); end
    end
    instr_valid = 1'b0;
  endtask

  task automatic test_handshake_hold();
    exp_t e, g;
    instr_valid = 1'b1; instr = 16'h8B05;
    sb.push_back(mk(1'b0, 1'b1, 3'd1, 3'd3, 3'd0, 1'b1, 8'h05, 1'b1, 1'b0, 8'h00, 1'b0));
    sb.push_back(idle_of(16'h8B05));
    sb.push_back(mk(1'b0, 1'b1, 3'd0, 3'd2, 3'd1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0));
    sb.push_back(idle_of(16'h4220));
    tick();
    instr = 16'h4220;
    for (int i = 0; i < 4; i++) begin
      e = sb.pop_front(); g = sample(); checks++;
      if (g !== e) begin errors++; $display("FAIL handshake_hold_%0d: got %h expected %h", i, g, e); end
      if (i == 2) instr_valid = 1'b0;
      if (i < 3) tick();
    end
  endtask

  initial begin
    test_reset();
    test_alu_reg();
    test_alu_imm();
    test_cmp_branch();
    test_branch_sweep();
    test_div_zero();
    test_reset_mid_exec();
    test_back_to_back();
    test_handshake_hold();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_ctrl.md
# alu_ctrl

Execute-stage sequencer that drives the ALU from the opposite side of its control interface. It accepts one 16-bit instruction at a time through a valid/ready handshake and drives the ALU operation select, enable and immediate path. It also drives the register-file write strobe. For branches it evaluates the ALU status word and issues a one-cycle branch request to the fetch logic.

## Interface
- `IW`, 16: instruction width. Fixed; other values are not supported.
- `clk  in  1`: rising-edge clock.
- `rst  in  1`: synchronous, active-high reset.
- `instr_valid  in  1`: an instruction is present on `instr`.
- `instr  in  16`: instruction word.
- `instr_ready  out  1`: the block can accept an instruction this cycle.
- `status_word  in  8`: ALU status, bits z|e|gt|lt|cf|0|0|0, MSB first.
- `rd_sel  out  3`: A-operand register and destination register.
- `rb_sel  out  3`: B-operand register.
- `alu_opr  out  3`: ALU opcode. ADD=0, SUB=1, MUL=2, DIV=3, AND=4, OR=5, XOR=6, CMP=7.
- `alu_en  out  1`: ALU enable.
- `direct_data_bus  out  8`: immediate operand.
- `direct_data_bus_en  out  1`: selects the immediate as the B operand.
- `reg_wr_en  out  1`: register-file write of the ALU result into `rd_sel`.
- `branch_taken  out  1`: one-cycle pulse requesting a jump.
- `branch_target  out  8`: jump address, valid while `branch_taken` is high.
- `div_zero_err  out  1`: one-cycle pulse.

## Operation
- **Instruction classes**, decoded from `instr[15:14]`:
  - 00 NOP.
  - 01 ALU-reg: `[13:11]` opr, `[10:8]` rd, `[7:5]` rb.
  - 10 ALU-imm: `[13:11]` opr, `[10:8]` rd, `[7:0]` imm.
  - 11 BRANCH: `[13:11]` cond, `[7:0]` target.
- **Branch conditions**:
  - 0 always, 1 Z, 2 E, 3 GT, 4 LT.
  - 5 GE (gt|e), 6 NE (!e), 7 LE (lt|e).
  - The CF bit is never used.
- **States**: IDLE, EXEC, BRANCH.
- **IDLE**:
  - `instr_ready`=1.
  - On `instr_valid`&&`instr_ready`, the instruction is latched into an internal register.
  - NOP stays in IDLE.
  - ALU-reg and ALU-imm go to EXEC.
  - BRANCH goes to BRANCH.
- **EXEC** (exactly one cycle):
  - `alu_en`=1; `alu_opr`, `rd_sel` and `rb_sel` are driven from the latched instruction.
  - For ALU-imm: `direct_data_bus_en`=1 and `direct_data_bus`=imm.
  - `reg_wr_en`=1 for every opr except CMP. CMP writes no register; the ALU updates its status on this edge.
  - Next state is IDLE.
- **ALU-imm DIV with imm=0**:
  - The instruction is suppressed: `alu_en`=0 and `reg_wr_en`=0.
  - `div_zero_err` pulses for one cycle in the EXEC slot.
  - Next state is IDLE.
  - ALU-reg DIV is not checked.
- **BRANCH** (exactly one cycle):
  - The condition is evaluated against the current `status_word`.
  - If true: `branch_taken`=1 and `branch_target`=target.
  - Next state is IDLE.
- **Outputs outside their active state**:
  - `alu_en`, `direct_data_bus_en`, `reg_wr_en`, `branch_taken` and `div_zero_err` are 0.
  - `direct_data_bus` and `branch_target` are 0.
  - `alu_opr`, `rd_sel` and `rb_sel` hold their last latched values.

## Timing
- **Reset**:
  - State goes to IDLE.
  - Every output is 0, including `instr_ready`, during the reset cycle.
  - The latched instruction is cleared to NOP.
  - `instr_ready` returns to 1 in the first cycle after `rst` deasserts.
- **Throughput and latency**:
  - Accept at edge N puts the block in EXEC or BRANCH during cycle N+1.
  - `instr_ready` is high again in cycle N+2, so ALU and branch instructions issue at one per 2 cycles.
  - NOPs issue at one per cycle.
- **Handshake**:
  - `instr` is sampled only on the handshake edge.
  - Changes to `instr` while `instr_ready`=0 are ignored.
  - The producer must hold `instr_valid` and `instr` until accepted.
- **Status word after CMP**: for a CMP in EXEC at cycle N+1, `status_word` is valid from cycle N+2. A branch accepted at the end of N+2 evaluates in N+3 and therefore sees the updated status. No interlock is required.
- **Reset mid-operation**: if `rst` is high during EXEC or BRANCH, the outputs of that cycle are still those of the state. The following cycle is IDLE with all outputs 0, and the instruction is discarded.
- **`instr_valid` in EXEC or BRANCH**: no accept takes place because `instr_ready`=0.

## Structure
- **Shared package `alu_pkg`**:
  - ALU opcode constants ADD..CMP.
  - Status-word bit indices (SW_Z=7, SW_E=6, SW_GT=5, SW_LT=4, SW_CF=3).
  - Instruction class codes.
  - Branch condition codes.
  - State encoding.
- **Sub-module `cond_eval`**: combinational, (`status_word`, cond) -> taken. It is reused later by the fetch unit.
- The remainder is a single FSM plus the latched instruction register.

## Test plan
- **ALU-reg ADD** (`instr`=0x4220: rd=2, rb=1), valid in IDLE:
  - Next cycle: `alu_en`=1, `alu_opr`=0, `rd_sel`=2, `rb_sel`=1, `reg_wr_en`=1, `direct_data_bus_en`=0.
  - `instr_ready` is 0 for that cycle and 1 the cycle after.
- **ALU-imm SUB** (`instr`=0x8B05: opr=1, rd=3, imm=5):
  - EXEC cycle: `direct_data_bus_en`=1, `direct_data_bus`=5, `alu_opr`=1, `rd_sel`=3, `reg_wr_en`=1.
- **CMP then branch**:
  - CMP reg (`instr`=0x7820) gives `alu_en`=1 and `reg_wr_en`=0.
  - Drive `status_word`=0x40 (e set), then issue BRANCH cond=2, target=0x3C (`instr`=0xD03C).
  - Required: `branch_taken`=1 and `branch_target`=0x3C for exactly one cycle.
  - Repeat with cond=6: required `branch_taken`=0.
- **Immediate DIV by zero** (`instr`=0x9900):
  - `div_zero_err`=1 for one cycle, with `alu_en`=0 and `reg_wr_en`=0.
  - `instr_ready` returns to 1 on schedule.
- **Reset mid-EXEC**: assert `rst` during EXEC of an ADD.
  - The cycle after: all outputs 0 and the instruction is not replayed.
  - The first cycle after deassert: `instr_ready`=1.
- **Back-to-back NOPs**: 4 NOPs with continuous `instr_valid`.
  - Accepted on 4 consecutive edges.
  - `instr_ready` stays 1 and no strobes are asserted.
